mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Sequencing and sharing controller for one combinational M x N array multiplier in the low-power multiplier datapath. It arbitrates round-robin between two requesters and registers the winning operands onto the multiplier inputs. Those inputs are held stable, with no toggling, until the next accepted request, for operand-isolation power savings. The controller waits a programmed number of settle cycles, then captures the product and returns it with a requester ID over a valid/ready response channel.

## Interface
- M, 4: multiplicand width (bits of operand a).
- N, 4: multiplier width (bits of operand b).
- SETTLE, 2: number of clock cycles the external array needs to settle. Legal values are 1 or more.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a / req0_b  input  M / N  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- mul_a  output  M  registered operand a driven to the array.
- mul_b  output  N  registered operand b driven to the array.
- mul_p  input  M+N  product from the array, unregistered.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_p  output  M+N  registered product.
- rsp_id  output  1  requester that issued the result (0 or 1).

## Operation
- There is one clock, and reset is synchronous and active-high.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: the grant is combinational. If exactly one reqX_valid is high, that requester is granted. If both are high, the requester selected by round-robin pointer rr is granted. reqX_ready = (state==IDLE) & grantX. At most one ready is high per cycle. ready may depend on valid.
  - IDLE to BUSY on handshake (reqX_valid & reqX_ready):
    - mul_a and mul_b are loaded from the granted operands.
    - id is loaded with X.
    - cnt is loaded with SETTLE-1.
    - rr is set to the non-granted requester.
  - BUSY: cnt decrements each cycle. When cnt==0, the next edge captures mul_p into rsp_p and id into rsp_id, sets rsp_valid, and moves to DONE.
  - DONE: rsp_valid is held high. rsp_p and rsp_id are held stable. On rsp_valid & rsp_ready, the next edge clears rsp_valid and returns to IDLE.
- Operand isolation: mul_a and mul_b change only on an accepted request. They keep their last value in IDLE, DONE and BUSY, and are never zeroed except by reset.
- Requesters must hold valid and operands stable until ready. Inputs seen when not accepted have no effect.
- Product width is exactly M+N, unsigned. There is no truncation or extension.
- Reset values:
  - state = IDLE, rr = 0, cnt = 0.
  - mul_a = 0, mul_b = 0.
  - rsp_valid = 0, rsp_p = 0, rsp_id = 0.
  - req0_ready and req1_ready are 0 during the reset cycle.

## Timing
- Latency: a request accepted at edge E0 gives rsp_valid = 1 after edge E(SETTLE). mul_a and mul_b are stable for the SETTLE cycles from E0 to E(SETTLE).
- Throughput: one operation per SETTLE+2 cycles when rsp_ready is held high. The cycles are accept, SETTLE cycles in BUSY, one DONE cycle, then one IDLE cycle before the next accept.
- Backpressure: rsp_ready low holds DONE indefinitely. No request is accepted, and mul_a, mul_b, rsp_p and rsp_id do not change.
- Simultaneous valid: with both valid and rr=0, requester 0 wins and rr becomes 1. The next contended grant goes to requester 1.
- A single valid is granted regardless of rr. rr still becomes the other requester.
- Reset mid-operation: reset in BUSY or DONE aborts the operation. No response is issued, all outputs take reset values on the next edge, and the aborted request is not replayed.
- A valid deasserted while not ready is legal and is simply never accepted.

## Test plan
- Single operation (M=N=4, SETTLE=2): req0 with a=7, b=9 -> req0_ready=1 for one cycle. mul_a=7 and mul_b=9 after the accept edge. rsp_valid rises 2 cycles after accept with rsp_p=63, rsp_id=0.
- Full-scale operands: req1 with a=15, b=15 -> rsp_p=225, rsp_id=1. Repeat with a=0, b=13 -> rsp_p=0.
- Contention and fairness: after reset, hold req0 (3,5) and req1 (6,7) valid continuously, rsp_ready=1.
  - Required response order: id0 with p=15, then id1 with p=42, then id0 with p=15 again.
  - Each result arrives SETTLE+2 = 4 cycles apart.
- Backpressure: with rsp_ready=0 for 10 cycles after rsp_valid, and req1 valid throughout, rsp_valid stays 1 and rsp_p stays stable. req1_ready stays 0 and mul_a/mul_b are unchanged. Raising rsp_ready for 1 cycle returns the FSM to IDLE, and req1 is accepted on the following cycle.
- Operand isolation: in IDLE, toggle req0_a and req0_b every cycle with both valids low for 20 cycles -> mul_a and mul_b show zero transitions.
- Reset mid-BUSY: accept req0 (5,5), then assert rst one cycle later -> rsp_valid is never asserted for that operation and all outputs are 0 after the reset edge. A new req1 (2,3) then yields rsp_p=6, rsp_id=1. This also checks that rr was reset.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing controller for one combinational M x N array multiplier.
// Operands are registered and held between accepts so the array inputs never toggle idly.
module mult_share_ctrl #(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [M-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [M-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic [M-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [M+N-1:0]   mul_p,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [M+N-1:0]   rsp_p,
    output logic             rsp_id
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [M-1:0]     mul_a_q, mul_a_d;
    logic [N-1:0]     mul_b_q, mul_b_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [M+N-1:0]   rsp_p_q, rsp_p_d;
    logic             rsp_id_q, rsp_id_d;

    logic             grant0_s, grant1_s;
    logic             acc0_s, acc1_s;

    // Combinational grant: a lone requester wins outright, a tie goes to rr.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = ~rr_q;
            grant1_s = rr_q;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    // Ready is masked during reset so nothing can be accepted on a reset edge.
    assign req0_ready = (state_q == S_IDLE) & grant0_s & ~rst;
    assign req1_ready = (state_q == S_IDLE) & grant1_s & ~rst;
    assign acc0_s     = req0_valid & req0_ready;
    assign acc1_s     = req1_valid & req1_ready;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (acc0_s || acc1_s) begin
                    state_d = S_BUSY;
                    mul_a_d = acc1_s ? req1_a : req0_a;
                    mul_b_d = acc1_s ? req1_b : req0_b;
                    id_d    = acc1_s;
                    cnt_d   = CNT_INIT;
                    rr_d    = acc0_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == {CW{1'b0}}) begin
                    rsp_p_d     = mul_p;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            mul_a_q     <= {M{1'b0}};
            mul_b_q     <= {N{1'b0}};
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= {(M+N){1'b0}};
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl (M=N=4, SETTLE=2) with an ideal combinational array.
module tb_mult_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_p;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_p;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mul_p = mul_a * mul_b;

    mult_share_ctrl #(.M(4), .N(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One operation from requester id, rsp_ready assumed high; starts and ends at a negedge.
    task automatic run_op(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p);
        int n;
        @(negedge clk);
        if (id == 1) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (((id == 1) ? req1_ready : req0_ready) !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check_eq({tag, "_ready"}, {31'd0, (id == 1) ? req1_ready : req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq({tag, "_mul_a"}, {28'd0, mul_a}, {28'd0, a});
        check_eq({tag, "_mul_b"}, {28'd0, mul_b}, {28'd0, b});
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check_eq({tag, "_latency"}, n, 32'd2);
        check_eq({tag, "_p"}, {24'd0, rsp_p}, {24'd0, exp_p});
        check_eq({tag, "_id"}, {31'd0, rsp_id}, id);
        @(negedge clk);
        check_eq({tag, "_released"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n, seen, trans;
        int          ids[3];
        int          ps[3];
        int          cyc[3];
        logic [3:0]  pa, pb;

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check_eq("rst_mul_a", {28'd0, mul_a}, 32'd0);
        check_eq("rst_mul_b", {28'd0, mul_b}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_p", {24'd0, rsp_p}, 32'd0);
        check_eq("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;

        run_op("single", 0, 4'd7, 4'd9, 8'd63);
        run_op("full", 1, 4'd15, 4'd15, 8'd225);
        run_op("zero", 1, 4'd0, 4'd13, 8'd0);

        // Contention: both held valid, responses must alternate every 4 cycles.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd7;
        seen = 0;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ids[seen] = int'(rsp_id);
                ps[seen]  = int'(rsp_p);
                cyc[seen] = c;
                seen++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("cont_count", seen, 32'd3);
        check_eq("cont_id0", ids[0], 32'd0);
        check_eq("cont_p0", ps[0], 32'd15);
        check_eq("cont_id1", ids[1], 32'd1);
        check_eq("cont_p1", ps[1], 32'd42);
        check_eq("cont_id2", ids[2], 32'd0);
        check_eq("cont_p2", ps[2], 32'd15);
        check_eq("cont_gap01", cyc[1] - cyc[0], 32'd4);
        check_eq("cont_gap12", cyc[2] - cyc[1], 32'd4);
        @(negedge clk);

        // Backpressure: result held, req1 locked out, operands frozen.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd4;
        #1;
        check_eq("bp_acc_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd3;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check_eq("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_p", {24'd0, rsp_p}, 32'd8);
            check_eq("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            check_eq("bp_mul_a", {28'd0, mul_a}, 32'd2);
            check_eq("bp_mul_b", {28'd0, mul_b}, 32'd4);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check_eq("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        check_eq("bp_next_mul_a", {28'd0, mul_a}, 32'd9);
        check_eq("bp_next_mul_b", {28'd0, mul_b}, 32'd3);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        check_eq("bp_next_p", {24'd0, rsp_p}, 32'd27);
        check_eq("bp_next_id", {31'd0, rsp_id}, 32'd1);
        @(negedge clk);

        // Operand isolation: toggling idle operands must not reach the array.
        trans = 0;
        pa = mul_a;
        pb = mul_b;
        for (int c = 0; c < 20; c++) begin
            req0_a = (c % 2 == 0) ? 4'hA : 4'h5;
            req0_b = (c % 2 == 0) ? 4'h5 : 4'hA;
            @(negedge clk);
            if (mul_a !== pa || mul_b !== pb) trans++;
            pa = mul_a;
            pb = mul_b;
        end
        check_eq("iso_transitions", trans, 32'd0);
        check_eq("iso_mul_a", {28'd0, mul_a}, 32'd9);
        check_eq("iso_mul_b", {28'd0, mul_b}, 32'd3);

        // Reset one cycle after accept aborts the operation.
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5;
        #1;
        check_eq("abort_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_mul_a", {28'd0, mul_a}, 32'd0);
        check_eq("abort_mul_b", {28'd0, mul_b}, 32'd0);
        check_eq("abort_rsp_p", {24'd0, rsp_p}, 32'd0);
        check_eq("abort_rsp_id", {31'd0, rsp_id}, 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        check_eq("abort_no_rsp", seen, 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("abort_rr_grant0", {31'd0, req0_ready}, 32'd1);
        check_eq("abort_rr_grant1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run_op("post_rst", 1, 4'd2, 4'd3, 8'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
